riscv_crypto_fu_sm3_msgexp: RTL and testbench

RISCV_CRYPTO_FU_SM3_MSGEXP -- requirements
Module: riscv_crypto_fu_sm3_msgexp

---
 rtl/riscv_crypto_fu_sm3_msgexp.sv | 84 ++++++++
 tb/tb_riscv_crypto_fu_sm3_msgexp.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_crypto_fu_sm3_msgexp.sv
// SM3 message expansion: takes one 512-bit block and streams (Wj, W'j) pairs
// from a 16-word sliding window, one pair per accepted output beat.
module riscv_crypto_fu_sm3_msgexp #(
  parameter int ROUNDS = 64
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_w,
  output logic [31:0]  out_wp,
  output logic [5:0]   out_idx,
  output logic         out_last
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] RUN      = 1'b1;
  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  logic [0:0]        state_q, state_d;
  logic [15:0][31:0] win_q, win_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              accept_in, beat, at_last;
  logic [31:0]       p1_in, w_next;

  function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol32(x, 15) ^ rol32(x, 23);
  endfunction

  assign accept_in = (state_q == IDLE) && in_valid;
  assign beat      = (state_q == RUN) && out_ready;
  assign at_last   = (cnt_q == LAST_IDX);

  // win[0..15] holds W[j..j+15]; the new word is W[j+16]
  assign p1_in  = win_q[0] ^ win_q[7] ^ rol32(win_q[13], 15);
  assign w_next = p1(p1_in) ^ rol32(win_q[3], 7) ^ win_q[10];

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    if (accept_in) begin
      for (int i = 0; i < 16; i++) win_d[i] = in_block[511 - 32*i -: 32];
      cnt_d   = '0;
      state_d = RUN;
    end else if (beat) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = w_next;
      if (at_last) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RUN);
  assign out_w     = win_q[0];
  assign out_wp    = win_q[0] ^ win_q[4];
  assign out_idx   = cnt_q;
  assign out_last  = out_valid && at_last;

endmodule

// File: tb/tb_riscv_crypto_fu_sm3_msgexp.sv
// Bench for the SM3 message expander: scoreboard fed from an independent
// full-array SM3 expansion, plus directed checks on a ROUNDS=1 instance.
module tb_riscv_crypto_fu_sm3_msgexp;

  logic         g_clk, g_resetn;
  logic         in_valid, in_ready, out_valid, out_ready, out_last;
  logic [511:0] in_block;
  logic [31:0]  out_w, out_wp;
  logic [5:0]   out_idx;

  logic         in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
  logic [511:0] in_block1;
  logic [31:0]  out_w1, out_wp1;
  logic [5:0]   out_idx1;

  riscv_crypto_fu_sm3_msgexp #(.ROUNDS(64)) u_dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_w(out_w), .out_wp(out_wp), .out_idx(out_idx), .out_last(out_last)
  );

  riscv_crypto_fu_sm3_msgexp #(.ROUNDS(1)) u_dut1 (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_block(in_block1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_w(out_w1), .out_wp(out_wp1), .out_idx(out_idx1), .out_last(out_last1)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] wp;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   acc_cyc[$];
  int   last_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference: textbook SM3 expansion into W[0..67]
  function automatic logic [31:0] ref_w(input logic [511:0] blk, input int j);
    logic [31:0] w [68];
    logic [31:0] t;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 68; i++) begin
      t    = w[i-16] ^ w[i-9] ^ rol(w[i-3], 15);
      w[i] = t ^ rol(t, 15) ^ rol(t, 23) ^ rol(w[i-13], 7) ^ w[i-6];
    end
    return w[j];
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Monitor: scoreboard compare, stall stability, handshake invariants
  logic        prev_stall = 1'b0;
  logic [31:0] hold_w, hold_wp;
  logic [5:0]  hold_idx;
  logic        hold_last;

  always @(negedge g_clk) begin
    exp_t e;
    cyc++;
    if (!g_resetn) begin
      prev_stall = 1'b0;
    end else begin
      check("rdy_vs_vld", 32'(in_ready), 32'(!out_valid));
      if (prev_stall) begin
        check("stall_vld", 32'(out_valid), 32'd1);
        check("stall_w", out_w, hold_w);
        check("stall_wp", out_wp, hold_wp);
        check("stall_idx", 32'(out_idx), 32'(hold_idx));
        check("stall_last", 32'(out_last), 32'(hold_last));
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(out_valid), 32'd0);
        end else begin
          e = sb[0];
          check("sb_w", out_w, e.w);
          check("sb_wp", out_wp, e.wp);
          check("sb_idx", 32'(out_idx), 32'(e.idx));
          check("sb_last", 32'(out_last), 32'(e.last));
          if (out_ready) begin
            void'(sb.pop_front());
            if (out_last) last_cyc.push_back(cyc);
          end
        end
      end else begin
        check("last_idle", 32'(out_last), 32'd0);
      end
      prev_stall = out_valid && !out_ready;
      hold_w     = out_w;
      hold_wp    = out_wp;
      hold_idx   = out_idx;
      hold_last  = out_last;
      if (in_valid && in_ready) begin
        for (int j = 0; j < 64; j++) begin
          e.w    = ref_w(in_block, j);
          e.wp   = ref_w(in_block, j) ^ ref_w(in_block, j + 4);
          e.idx  = 6'(j);
          e.last = (j == 63);
          sb.push_back(e);
        end
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [511:0] blk, input bit keep);
    int k;
    in_valid = 1'b1;
    in_block = blk;
    for (k = 0; k < 300; k++) begin
      @(negedge g_clk);
      if (in_ready) break;
    end
    if (k == 300) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge g_clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge g_clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sb.size() == 0 && !out_valid) break;
    end
    if (k == budget) begin
      check("drain_timeout", 32'(out_valid), 32'd0);
      check("drain_left", sb.size(), 32'd0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int k;
    in_valid  = 1'b0; in_block  = '0; out_ready  = 1'b1;
    in_valid1 = 1'b0; in_block1 = '0; out_ready1 = 1'b0;
    g_resetn  = 1'b1;
    #1 g_resetn = 1'b0;
    #2;
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_w", out_w, 32'd0);
    check("rst_wp", out_wp, 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_rdy1", 32'(in_ready1), 32'd1);

    // "abc" block presented during reset, accepted on first edge after release
    in_valid = 1'b1;
    in_block = ABC;
    #5 g_resetn = 1'b1;
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    for (k = 0; k < 64; k++) begin
      @(negedge g_clk);
      check("abc_vld", 32'(out_valid), 32'd1);
      check("abc_idx", 32'(out_idx), 32'(k));
      check("abc_last", 32'(out_last), 32'(k == 63));
      if (k == 0) begin
        check("abc_w0", out_w, 32'h61626380);
        check("abc_wp0", out_wp, 32'h61626380);
      end
      if (k == 12) check("abc_wp12", out_wp, 32'h9092e200);
      if (k == 16) check("abc_w16", out_w, 32'h9092e200);
    end
    @(negedge g_clk);
    check("abc_done", 32'(out_valid), 32'd0);
    check("abc_sb_empty", sb.size(), 32'd0);

    // Random blocks under random backpressure
    for (int b = 0; b < 3; b++) begin
      send(rand_block(), 1'b0);
      drain(1'b1, 1000);
    end

    // in_valid held across two blocks: second accepted right after j=63
    acc_cyc.delete();
    last_cyc.delete();
    out_ready = 1'b1;
    send(rand_block(), 1'b1);
    send(rand_block(), 1'b0);
    drain(1'b0, 300);
    check("b2b_acc_n", acc_cyc.size(), 32'd2);
    check("b2b_last_n", last_cyc.size(), 32'd2);
    if (acc_cyc.size() == 2 && last_cyc.size() >= 1)
      check("b2b_gap", acc_cyc[1], last_cyc[0] + 1);

    // Reset mid-block at j=30
    send(rand_block(), 1'b0);
    for (k = 0; k < 200; k++) begin
      @(negedge g_clk);
      if (out_valid && out_idx == 6'd30) break;
    end
    check("wait_j30", 32'(out_idx), 32'd30);
    #2 g_resetn = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_vld", 32'(out_valid), 32'd0);
    check("mid_rst_w", out_w, 32'd0);
    check("mid_rst_wp", out_wp, 32'd0);
    check("mid_rst_idx", 32'(out_idx), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_rdy", 32'(in_ready), 32'd1);
    @(posedge g_clk);
    @(posedge g_clk);
    #3 g_resetn = 1'b1;
    repeat (3) @(negedge g_clk);
    send(rand_block(), 1'b0);
    drain(1'b1, 1000);

    // ROUNDS=1 instance: single beat then straight back to IDLE
    in_valid1 = 1'b1;
    in_block1 = ABC;
    @(negedge g_clk);
    check("r1_rdy", 32'(in_ready1), 32'd1);
    @(posedge g_clk); #1;
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;
    @(negedge g_clk);
    check("r1_vld", 32'(out_valid1), 32'd1);
    check("r1_w", out_w1, 32'h61626380);
    check("r1_wp", out_wp1, 32'h61626380);
    check("r1_idx", 32'(out_idx1), 32'd0);
    check("r1_last", 32'(out_last1), 32'd1);
    @(negedge g_clk);
    check("r1_idle_vld", 32'(out_valid1), 32'd0);
    check("r1_idle_rdy", 32'(in_ready1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
